// File: rtl/proc.sv
// Four-bit accumulator processor running a fixed 16-entry program.
// One instruction retires per clock; pc and the accumulator are visible.
module proc (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] pc,
    output logic [3:0] result
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BEQZ = 4'hC;
    localparam logic [3:0] OP_BNEZ = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;

    logic [3:0] acc;
    logic [3:0] regs [4];
    logic       halted;
    logic [7:0] instr;
    logic [3:0] op;
    logic [3:0] imm;

    // Program ROM: countdown loop, reload, then halt.
    always_comb begin
        instr = {OP_NOP, 4'h0};
        case (pc)
            4'd0:    instr = {OP_LDI,  4'd3};
            4'd1:    instr = {OP_ADDI, 4'd4};
            4'd2:    instr = {OP_ST,   4'd0};
            4'd3:    instr = {OP_SUBI, 4'd1};
            4'd4:    instr = {OP_BNEZ, 4'd3};
            4'd5:    instr = {OP_LD,   4'd0};
            4'd6:    instr = {OP_XORI, 4'd5};
            4'd7:    instr = {OP_SHL,  4'd0};
            4'd8:    instr = {OP_HALT, 4'd0};
            default: instr = {OP_NOP,  4'd0};
        endcase
    end

    assign op     = instr[7:4];
    assign imm    = instr[3:0];
    assign result = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= 4'd0;
            acc    <= 4'd0;
            halted <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
        end else if (!halted) begin
            pc <= pc + 4'd1;
            case (op)
                OP_LDI:  acc <= imm;
                OP_ADDI: acc <= acc + imm;
                OP_SUBI: acc <= acc - imm;
                OP_ANDI: acc <= acc & imm;
                OP_ORI:  acc <= acc | imm;
                OP_XORI: acc <= acc ^ imm;
                OP_SHL:  acc <= {acc[2:0], 1'b0};
                OP_SHR:  acc <= {1'b0, acc[3:1]};
                OP_ST:   regs[imm[1:0]] <= acc;
                OP_LD:   acc <= regs[imm[1:0]];
                OP_JMP:  pc <= imm;
                OP_BEQZ: if (acc == 4'd0) pc <= imm;
                OP_BNEZ: if (acc != 4'd0) pc <= imm;
                OP_HALT: begin
                    halted <= 1'b1;
                    pc     <= pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc.sv
// Bench for proc: ISA-level reference model checked every cycle,
// plus literal trace tables and model spot checks.
module tb_proc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pc;
    logic [3:0] result;

    int errors = 0;
    int checks = 0;

    proc dut (
        .clk    (clk),
        .reset  (reset),
        .pc     (pc),
        .result (result)
    );

    always #5 clk = ~clk;

    // Program as (opcode, immediate) pairs.
    int rom_op  [16] = '{1, 2, 9, 3, 13, 10, 6, 7, 14, 0, 0, 0, 0, 0, 0, 0};
    int rom_imm [16] = '{3, 4, 0, 1, 3,  0,  5, 0, 0,  0, 0, 0, 0, 0, 0, 0};

    int m_pc, m_acc, m_halt;
    int m_regs [4];
    bit armed = 0;

    int trace_pc  [21] = '{0,1,2,3,4,3,4,3,4,3,4,3,4,3,4,3,4,5,6,7,8};
    int trace_acc [21] = '{0,3,7,7,6,6,5,5,4,4,3,3,2,2,1,1,0,0,7,2,4};

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One instruction in plain modulo-16 arithmetic.
    task automatic exec(input int op, input int imm, input int acc_i,
                        input int pc_i, output int acc_o, output int pc_o,
                        output int halt_o);
        acc_o  = acc_i;
        pc_o   = (pc_i + 1) % 16;
        halt_o = 0;
        case (op)
            1:  acc_o = imm;
            2:  acc_o = (acc_i + imm) % 16;
            3:  acc_o = (acc_i - imm + 16) % 16;
            4:  acc_o = acc_i & imm;
            5:  acc_o = acc_i | imm;
            6:  acc_o = acc_i ^ imm;
            7:  acc_o = (acc_i * 2) % 16;
            8:  acc_o = acc_i / 2;
            10: acc_o = m_regs[imm % 4];
            11: pc_o = imm;
            12: if (acc_i == 0) pc_o = imm;
            13: if (acc_i != 0) pc_o = imm;
            14: begin halt_o = 1; pc_o = pc_i; end
            default: ;
        endcase
    endtask

    task automatic model_step();
        int a, p, h;
        if (m_halt != 0) return;
        exec(rom_op[m_pc], rom_imm[m_pc], m_acc, m_pc, a, p, h);
        if (rom_op[m_pc] == 9) m_regs[rom_imm[m_pc] % 4] = m_acc;
        m_acc  = a;
        m_pc   = p;
        m_halt = h;
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0; m_acc = 0; m_halt = 0;
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            armed = 1;
        end else if (armed) begin
            model_step();
        end
        #1;
        if (armed) begin
            checks++;
            if ($isunknown({pc, result})) begin
                errors++;
                $display("FAIL xcheck: pc=%b result=%b", pc, result);
            end
            check("model_pc", int'(pc), m_pc);
            check("model_acc", int'(result), m_acc);
        end
    end

    task automatic trace_from(input int first, input int last, input string tag);
        for (int k = first; k <= last; k++) begin
            if (k > first) @(negedge clk);
            check({tag, "_pc"}, int'(pc), trace_pc[k]);
            check({tag, "_acc"}, int'(result), trace_acc[k]);
        end
    endtask

    initial begin
        int a, p, h;
        // Model spot checks on arithmetic and pc wrap.
        exec(2, 15, 1, 0, a, p, h); check("pin_addi_wrap", a, 0);
        exec(7, 0, 9, 0, a, p, h);  check("pin_shl", a, 2);
        exec(8, 0, 9, 0, a, p, h);  check("pin_shr", a, 4);
        exec(3, 1, 0, 0, a, p, h);  check("pin_subi_wrap", a, 15);
        exec(0, 0, 5, 15, a, p, h); check("pin_pc_wrap", p, 0);
        exec(6, 5, 7, 6, a, p, h);  check("pin_xori", a, 2);

        // Held reset keeps state at zero.
        repeat (3) @(negedge clk);
        check("reset_pc", int'(pc), 0);
        check("reset_acc", int'(result), 0);
        reset = 1'b0;
        trace_from(0, 20, "trace");
        repeat (6) begin
            @(negedge clk);
            check("halt_pc", int'(pc), 8);
            check("halt_acc", int'(result), 4);
        end

        // Reset while halted, then full rerun.
        reset = 1'b1;
        @(negedge clk);
        check("hreset_pc", int'(pc), 0);
        check("hreset_acc", int'(result), 0);
        reset = 1'b0;
        trace_from(0, 10, "rerun");

        // Mid-program reset at (4,3), then identical restart.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        trace_from(0, 20, "restart");
        repeat (4) @(negedge clk);
        check("final_pc", int'(pc), 8);
        check("final_acc", int'(result), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
